// File: rtl/axi4_read_arbiter_pkg.sv
// Shared AXI4 read-side types for the read arbiter and its interfaces.
// Holds the fixed-width AR field types, the response type and the arbiter FSM state.
package axi4_read_arbiter_pkg;

  typedef logic [7:0] axi4_len_t;
  typedef logic [2:0] axi4_size_t;
  typedef logic [1:0] axi4_burst_t;
  typedef logic [1:0] axi4_resp_t;
  typedef logic [3:0] axi4_cache_t;
  typedef logic [2:0] axi4_prot_t;
  typedef logic [3:0] axi4_qos_t;
  typedef logic [3:0] axi4_region_t;

  localparam axi4_burst_t Axi4BurstFixed = 2'b00;
  localparam axi4_burst_t Axi4BurstIncr  = 2'b01;
  localparam axi4_burst_t Axi4BurstWrap  = 2'b10;

  localparam axi4_resp_t Axi4RespOkay   = 2'b00;
  localparam axi4_resp_t Axi4RespExokay = 2'b01;
  localparam axi4_resp_t Axi4RespSlverr = 2'b10;
  localparam axi4_resp_t Axi4RespDecerr = 2'b11;

  // Width of the AR payload fields whose size does not depend on a parameter
  // (len, size, burst, lock, cache, prot, qos, region).
  localparam int unsigned Axi4ArFixedW = 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } axi4_rd_arb_state_t;

endpackage

// File: rtl/axi4_read_arbiter_if.sv
// AXI4 read address (AR) and read data (R) channel interfaces.
// Modport "out" belongs to the side that drives valid/payload, "in" to the side that
// receives it and drives ready.
interface axi4_ar_intf
  import axi4_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
) ();
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  axi4_len_t             arlen;
  axi4_size_t            arsize;
  axi4_burst_t           arburst;
  logic                  arlock;
  axi4_cache_t           arcache;
  axi4_prot_t            arprot;
  axi4_qos_t             arqos;
  axi4_region_t          arregion;
  logic [USER_WIDTH-1:0] aruser;

  modport out (
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser,
    input  arready
  );

  modport in (
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser,
    output arready
  );
endinterface

interface axi4_r_intf
  import axi4_read_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1
) ();
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  axi4_resp_t            rresp;
  logic [ID_WIDTH-1:0]   rid;

  modport out (
    output rvalid, rdata, rlast, rresp, rid,
    input  rready
  );

  modport in (
    input  rvalid, rdata, rlast, rresp, rid,
    output rready
  );
endinterface

// File: rtl/axi4_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or above
// ptr_i, wrapping from N-1 back to 0.
//   req_i         - request vector
//   ptr_i         - highest-priority index this cycle
//   grant_valid_o - at least one request is asserted
//   grant_idx_o   - index of the winning request
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            grant_valid_o,
  output logic [IdxW-1:0] grant_idx_o
);

  int unsigned idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr_i) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!grant_valid_o && req_i[IdxW'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Shares one downstream AXI4 read port between NUM_REQUESTERS upstream masters.
// One burst in flight: arbitrate in idle, replay the captured AR downstream, then
// route R beats to the granted requester until the rlast handshake.
//   clk, rst - clock and synchronous active-high reset
//   ar_in    - upstream AR channels (one per requester)
//   r_out    - upstream R channels (one per requester)
//   ar_out   - downstream AR channel
//   r_in     - downstream R channel
module axi4_read_arbiter
  import axi4_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned USER_WIDTH     = 1,
  parameter int unsigned ID_WIDTH       = 1
) (
  input  logic     clk,
  input  logic     rst,
  axi4_ar_intf.in  ar_in [NUM_REQUESTERS],
  axi4_r_intf.out  r_out [NUM_REQUESTERS],
  axi4_ar_intf.out ar_out,
  axi4_r_intf.in   r_in
);

  localparam int unsigned IdxW = $clog2(NUM_REQUESTERS);
  localparam int unsigned ArW  = ID_WIDTH + ADDR_WIDTH + Axi4ArFixedW + USER_WIDTH;

  axi4_rd_arb_state_t state_q, state_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [ArW-1:0]     ar_q, ar_d;

  logic [NUM_REQUESTERS-1:0] up_arvalid, up_arready, up_rvalid, up_rready;
  logic [ArW-1:0]            up_ar [NUM_REQUESTERS];
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      win_valid;
  logic [IdxW-1:0]           win_idx;
  logic                      ar_valid;
  logic                      r_ready;

  // Flatten the interface arrays so the FSM can index them with a variable.
  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_up
    assign up_arvalid[g]   = ar_in[g].arvalid;
    assign up_ar[g]        = {ar_in[g].arid, ar_in[g].araddr, ar_in[g].arlen, ar_in[g].arsize,
                              ar_in[g].arburst, ar_in[g].arlock, ar_in[g].arcache,
                              ar_in[g].arprot, ar_in[g].arqos, ar_in[g].arregion,
                              ar_in[g].aruser};
    assign ar_in[g].arready = up_arready[g];

    assign r_out[g].rvalid = up_rvalid[g];
    assign r_out[g].rdata  = rdata;
    assign r_out[g].rlast  = r_in.rlast;
    assign r_out[g].rresp  = r_in.rresp;
    assign r_out[g].rid    = r_in.rid;
    assign up_rready[g]    = r_out[g].rready;
  end

  assign rdata = r_in.rdata;

  rr_arbiter #(
    .N (NUM_REQUESTERS)
  ) u_rr_arbiter (
    .req_i         (up_arvalid),
    .ptr_i         (rr_q),
    .grant_valid_o (win_valid),
    .grant_idx_o   (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    ar_d       = ar_q;
    up_arready = '0;
    up_rvalid  = '0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    case (state_q)
      StIdle: begin
        // The winner already has arvalid high, so arready completes the handshake.
        if (win_valid) begin
          up_arready[win_idx] = 1'b1;
          ar_d                = up_ar[win_idx];
          grant_d             = win_idx;
          state_d             = StAddr;
        end
      end
      StAddr: begin
        ar_valid = 1'b1;
        if (ar_out.arready) begin
          state_d = StData;
        end
      end
      StData: begin
        up_rvalid[grant_q] = r_in.rvalid;
        r_ready            = up_rready[grant_q];
        if (r_in.rvalid && r_ready && r_in.rlast) begin
          state_d = StIdle;
          rr_d    = (grant_q == IdxW'(NUM_REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Captured AR payload needs no reset: it is only driven out while arvalid is high.
  always_ff @(posedge clk) begin
    ar_q <= ar_d;
  end

  assign ar_out.arvalid = ar_valid;
  assign {ar_out.arid, ar_out.araddr, ar_out.arlen, ar_out.arsize, ar_out.arburst,
          ar_out.arlock, ar_out.arcache, ar_out.arprot, ar_out.arqos, ar_out.arregion,
          ar_out.aruser} = ar_q;
  assign r_in.rready = r_ready;

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Randomized bench for axi4_read_arbiter: requesters and a memory slave are modelled
// here, and a transaction-level reference predicts every handshake output per cycle.
module tb_axi4_read_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 1;
  localparam int unsigned IW = 1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          lock;
    logic [3:0]    cache;
    logic [2:0]    prot;
    logic [3:0]    qos;
    logic [3:0]    region;
    logic [UW-1:0] user;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_ar_intf #(.ADDR_WIDTH(AW), .USER_WIDTH(UW), .ID_WIDTH(IW)) ar_in_if [N] ();
  axi4_r_intf  #(.DATA_WIDTH(DW), .ID_WIDTH(IW))                  r_out_if [N] ();
  axi4_ar_intf #(.ADDR_WIDTH(AW), .USER_WIDTH(UW), .ID_WIDTH(IW)) ar_out_if ();
  axi4_r_intf  #(.DATA_WIDTH(DW), .ID_WIDTH(IW))                  r_in_if ();

  logic [N-1:0]  m_arvalid = '0, m_rready = '0;
  logic [N-1:0]  m_arready, m_rvalid, m_rlast;
  req_t          m_ar [N];
  logic [DW-1:0] m_rdata [N];
  logic [1:0]    m_rresp [N];
  logic [IW-1:0] m_rid [N];

  logic          s_arvalid, s_rready;
  logic          s_arready = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0;
  req_t          s_ar;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = '0;
  logic [IW-1:0] s_rid = '0;

  for (genvar g = 0; g < N; g++) begin : g_up
    assign ar_in_if[g].arvalid = m_arvalid[g];
    assign {ar_in_if[g].arid, ar_in_if[g].araddr, ar_in_if[g].arlen, ar_in_if[g].arsize,
            ar_in_if[g].arburst, ar_in_if[g].arlock, ar_in_if[g].arcache, ar_in_if[g].arprot,
            ar_in_if[g].arqos, ar_in_if[g].arregion, ar_in_if[g].aruser} = m_ar[g];
    assign m_arready[g]       = ar_in_if[g].arready;
    assign m_rvalid[g]        = r_out_if[g].rvalid;
    assign m_rdata[g]         = r_out_if[g].rdata;
    assign m_rlast[g]         = r_out_if[g].rlast;
    assign m_rresp[g]         = r_out_if[g].rresp;
    assign m_rid[g]           = r_out_if[g].rid;
    assign r_out_if[g].rready = m_rready[g];
  end

  assign s_arvalid = ar_out_if.arvalid;
  assign s_ar      = {ar_out_if.arid, ar_out_if.araddr, ar_out_if.arlen, ar_out_if.arsize,
                      ar_out_if.arburst, ar_out_if.arlock, ar_out_if.arcache, ar_out_if.arprot,
                      ar_out_if.arqos, ar_out_if.arregion, ar_out_if.aruser};
  assign ar_out_if.arready = s_arready;
  assign r_in_if.rvalid    = s_rvalid;
  assign r_in_if.rdata     = s_rdata;
  assign r_in_if.rlast     = s_rlast;
  assign r_in_if.rresp     = s_rresp;
  assign r_in_if.rid       = s_rid;
  assign s_rready          = r_in_if.rready;

  axi4_read_arbiter #(
    .NUM_REQUESTERS (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .USER_WIDTH     (UW),
    .ID_WIDTH       (IW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ar_in  (ar_in_if),
    .r_out  (r_out_if),
    .ar_out (ar_out_if),
    .r_in   (r_in_if)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs (percentages).
  logic [N-1:0] mask = '0;
  int want_prob = 0, drop_prob = 0, sar_prob = 100, rv_prob = 100, rr_prob = 100;
  int fix_len = -1;
  logic rst_req = 1'b1;

  // Requester state.
  logic [N-1:0] want = '0;
  req_t cur_req [N];
  logic [N-1:0] rx_active = '0;
  int rx_len [N];
  int rx_cnt [N];
  int rx_total [N];

  // Slave state.
  logic sl_active = 1'b0;
  logic s_taken = 1'b0;
  int sl_len = 0, sl_beat = 0;
  logic [IW-1:0] sl_id = '0;
  logic [15:0] sl_tag = '0;
  logic [AW-1:0] last_down_addr = '0;

  // Reference: at most one burst owned; it is either awaiting its downstream AR or streaming.
  logic busy = 1'b0, pend = 1'b0;
  int owner = 0, prio = 0;
  req_t mdl_ar;
  int grants[$];

  function automatic req_t mk_req(input logic [AW-1:0] addr, input int len, input int id);
    req_t r;
    r = '0;
    r.addr  = addr;
    r.len   = 8'(len);
    r.id    = IW'(id);
    r.size  = 3'd2;
    r.burst = 2'b01;
    return r;
  endfunction

  function automatic req_t new_req();
    req_t r;
    r.id     = IW'($urandom);
    r.addr   = $urandom;
    r.len    = (fix_len >= 0) ? 8'(fix_len) : 8'($urandom_range(7));
    r.size   = 3'($urandom);
    r.burst  = 2'($urandom);
    r.lock   = 1'($urandom);
    r.cache  = 4'($urandom);
    r.prot   = 3'($urandom);
    r.qos    = 4'($urandom);
    r.region = 4'($urandom);
    r.user   = UW'($urandom);
    return r;
  endfunction

  task automatic drive();
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      if (!want[i] && mask[i] && ($urandom_range(99) < want_prob)) begin
        want[i]    = 1'b1;
        cur_req[i] = new_req();
      end else if (want[i] && ($urandom_range(99) < drop_prob)) begin
        want[i] = 1'b0;
      end
      m_arvalid[i] = want[i] && mask[i] && !rst_req;
      m_ar[i]      = cur_req[i];
      m_rready[i]  = ($urandom_range(99) < rr_prob);
    end
    s_arready = ($urandom_range(99) < sar_prob);
    if (s_taken) begin
      s_rvalid = 1'b0;
      s_taken  = 1'b0;
    end
    if (!s_rvalid && sl_active && ($urandom_range(99) < rv_prob)) begin
      s_rvalid = 1'b1;
      s_rdata  = {sl_tag, 16'(sl_beat)};
      s_rlast  = (sl_beat == sl_len);
      s_rid    = sl_id;
      s_rresp  = 2'($urandom);
    end
  endtask

  task automatic check_update();
    int win;
    logic [N-1:0] exp_ready;
    logic exp_arv, exp_rr, exp_rv;
    win = -1;
    if (!busy) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (prio + off) % N;
        if (win < 0 && m_arvalid[k]) win = k;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    exp_arv = busy && pend;
    exp_rr  = busy && !pend && m_rready[owner];
    check_eq("up_arready", 64'(m_arready), 64'(exp_ready));
    check_eq("down_arvalid", 64'(s_arvalid), 64'(exp_arv));
    if (exp_arv) check_eq("down_ar_fields", 64'(s_ar), 64'(mdl_ar));
    check_eq("down_rready", 64'(s_rready), 64'(exp_rr));
    for (int i = 0; i < N; i++) begin
      exp_rv = busy && !pend && (owner == i) && s_rvalid;
      check_eq($sformatf("up%0d_rvalid", i), 64'(m_rvalid[i]), 64'(exp_rv));
      if (exp_rv) begin
        check_eq($sformatf("up%0d_rbeat", i), 64'({m_rdata[i], m_rlast[i], m_rresp[i], m_rid[i]}),
                 64'({s_rdata, s_rlast, s_rresp, s_rid}));
      end
    end

    // Requesters: what each one sees of its own burst, in order.
    for (int i = 0; i < N; i++) begin
      if (m_rvalid[i] && m_rready[i]) begin
        check_eq($sformatf("up%0d_rx_owned", i), 64'(rx_active[i]), 64'd1);
        check_eq($sformatf("up%0d_rx_index", i), 64'(m_rdata[i][15:0]), 64'(rx_cnt[i]));
        check_eq($sformatf("up%0d_rx_last", i), 64'(m_rlast[i]), 64'(rx_cnt[i] == rx_len[i]));
        rx_cnt[i]++;
        rx_total[i]++;
        if (m_rlast[i]) rx_active[i] = 1'b0;
      end
      if (m_arvalid[i] && m_arready[i]) begin
        want[i]      = 1'b0;
        rx_active[i] = 1'b1;
        rx_len[i]    = int'(cur_req[i].len);
        rx_cnt[i]    = 0;
      end
    end

    // Slave.
    if (s_rvalid && s_rready) begin
      s_taken = 1'b1;
      sl_beat++;
      if (s_rlast) sl_active = 1'b0;
    end
    if (s_arvalid && s_arready) begin
      sl_active      = 1'b1;
      sl_len         = int'(s_ar.len);
      sl_id          = s_ar.id;
      sl_beat        = 0;
      sl_tag         = 16'($urandom);
      last_down_addr = s_ar.addr;
    end

    // Reference progress.
    if (!busy) begin
      if (win >= 0) begin
        busy   = 1'b1;
        pend   = 1'b1;
        owner  = win;
        mdl_ar = m_ar[win];
        grants.push_back(win);
      end
    end else if (pend) begin
      if (s_arready) pend = 1'b0;
    end else if (s_rvalid && m_rready[owner] && s_rlast) begin
      busy = 1'b0;
      prio = (owner + 1) % N;
    end

    if (rst_req) begin
      busy      = 1'b0;
      pend      = 1'b0;
      prio      = 0;
      sl_active = 1'b0;
      s_taken   = 1'b1;
      rx_active = '0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  initial begin
    int base;
    logic done;
    for (int i = 0; i < N; i++) begin
      cur_req[i]  = '0;
      m_ar[i]     = '0;
      rx_len[i]   = 0;
      rx_cnt[i]   = 0;
      rx_total[i] = 0;
    end

    // Reset state.
    rst_req = 1'b1;
    cycle();
    cycle();
    check_eq("rst_arvalid", 64'(s_arvalid), 64'd0);
    check_eq("rst_rready", 64'(s_rready), 64'd0);
    check_eq("rst_up_rvalid", 64'(m_rvalid), 64'd0);
    check_eq("rst_up_arready", 64'(m_arready), 64'd0);
    rst_req = 1'b0;

    // Single 4-beat burst from requester 0.
    mask       = 2'b01;
    cur_req[0] = mk_req(32'h1000, 3, 1);
    want[0]    = 1'b1;
    for (int c = 0; c < 100 && !(grants.size() == 1 && !busy); c++) cycle();
    done = (grants.size() == 1) && !busy;
    check_eq("single_done", 64'(done), 64'd1);
    check_eq("single_down_addr", 64'(last_down_addr), 64'h1000);
    check_eq("single_beats_req0", 64'(rx_total[0]), 64'd4);
    check_eq("single_beats_req1", 64'(rx_total[1]), 64'd0);

    // Simultaneous requests after reset, then fairness with both always valid.
    rst_req = 1'b1;
    cycle();
    rst_req    = 1'b0;
    mask       = 2'b11;
    fix_len    = 0;
    want_prob  = 100;
    cur_req[0] = mk_req(32'h100, 0, 0);
    cur_req[1] = mk_req(32'h200, 0, 1);
    want       = 2'b11;
    base       = grants.size();
    for (int c = 0; c < 200 && grants.size() < base + 6; c++) cycle();
    done = (grants.size() >= base + 6);
    check_eq("fair_done", 64'(done), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("fair_grant%0d", k), 64'(grants[base + k]), 64'(k % 2));
    end

    // Random traffic with AR and R backpressure and requests withdrawn before grant.
    fix_len   = -1;
    want_prob = 40;
    drop_prob = 5;
    sar_prob  = 50;
    rv_prob   = 60;
    rr_prob   = 70;
    for (int c = 0; c < 600; c++) cycle();
    want_prob = 0;
    mask      = '0;
    for (int c = 0; c < 300 && busy; c++) cycle();
    check_eq("random_drained", 64'(busy), 64'd0);

    // Reset in the middle of a 4-beat burst.
    drop_prob  = 0;
    want       = '0;
    mask       = 2'b01;
    cur_req[0] = mk_req(32'h3000, 3, 0);
    want[0]    = 1'b1;
    for (int c = 0; c < 200 && !(rx_active[0] && rx_cnt[0] == 2); c++) cycle();
    done = rx_active[0] && (rx_cnt[0] == 2);
    check_eq("midrst_reached", 64'(done), 64'd1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    mask    = '0;
    cycle();
    check_eq("midrst_arvalid", 64'(s_arvalid), 64'd0);
    check_eq("midrst_rready", 64'(s_rready), 64'd0);
    check_eq("midrst_up_rvalid", 64'(m_rvalid), 64'd0);
    check_eq("midrst_up_arready", 64'(m_arready), 64'd0);
    mask       = 2'b11;
    cur_req[0] = mk_req(32'h4000, 1, 0);
    cur_req[1] = mk_req(32'h5000, 2, 1);
    want       = 2'b11;
    base       = grants.size();
    for (int c = 0; c < 200 && !(grants.size() >= base + 2 && !busy); c++) cycle();
    done = (grants.size() >= base + 2) && !busy;
    check_eq("postrst_done", 64'(done), 64'd1);
    check_eq("postrst_grant0", 64'(grants[base]), 64'd0);
    check_eq("postrst_grant1", 64'(grants[base + 1]), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
